line_buffer_writer: RTL and testbench
=====================================

Name: line_buffer_writer

Overview:
- Write-side counterpart of the filter-window read controller.
- Accepts the raw pixel stream, writes pixels into a rotating set of three line buffers and drives the `en` stream that the read controller consumes.
- Tracks column and row position, flags line and frame boundaries, and after the last pixel keeps `en` high for a programmable flush period so the filter pipeline drains.
- Sits between the video input interface and the line-buffer/window stage.

Parameters:
- IMG_W, 640, active pixels per line.
- IMG_H, 480, lines per frame.
- DATA_W, 8, pixel width in bits.
- COL_W, 10, column counter and write-address width; must satisfy 2^COL_W >= IMG_W.
- ROW_W, 9, row counter width; must satisfy 2^ROW_W >= IMG_H.
- FLUSH_CYCLES, 16, cycles `en` stays high after the last pixel; legal range is 1 to 65535.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input pixel valid.
- in_data  in  DATA_W  input pixel.
- in_ready  out  1  writer can accept a pixel.
- wr_en  out  1  line-buffer write strobe.
- wr_addr  out  COL_W  line-buffer write address, equal to the column.
- wr_data  out  DATA_W  pixel to write.
- wr_sel  out  2  target line buffer: 0, 1 or 2.
- en  out  1  enable toward the read controller.
- sof  out  1  start-of-frame; qualifies the wr_en of pixel (0,0).
- eol  out  1  end-of-line; qualifies the wr_en of the last column.
- eof  out  1  end-of-frame; qualifies the wr_en of the last pixel.
- frame_done  out  1  single-cycle pulse when the flush period completes.

Behaviour:
- Reset: synchronous and active-high.
  - State goes to IDLE.
  - col, row, wr_sel and the flush counter clear to 0.
  - wr_en, en, sof, eol, eof and frame_done go to 0.
  - wr_addr and wr_data go to 0.
  - in_ready goes to 0 while rst=1.
  - A reset mid-frame abandons the frame; no frame_done is issued.
- States: IDLE, FILL, FLUSH, DONE.
- in_ready is 1 in IDLE and FILL, and 0 in FLUSH and DONE.
- Accept: a pixel is accepted when in_valid=1 and in_ready=1.
- Write timing: latency is 1 cycle. On the cycle after an accept:
  - wr_en=1 and en=1.
  - wr_addr = col at accept, wr_data = in_data, wr_sel = current buffer.
  - In any cycle with no accept, wr_en=0 on the next cycle.
- `en` behaviour:
  - In IDLE and FILL, en mirrors the registered wr_en.
  - In FLUSH, en is held at 1.
  - In DONE, en=0.
- Counters, on each accept:
  - col increments; it wraps from IMG_W-1 to 0.
  - On that wrap, row increments and wr_sel advances 0→1→2→0.
  - row wraps from IMG_H-1 to 0 at end of frame.
- Boundary flags are registered alongside wr_en:
  - sof for (col=0, row=0).
  - eol for col=IMG_W-1.
  - eof for (col=IMG_W-1, row=IMG_H-1).
  - On the last pixel, eol and eof are both high.
- Transitions:
  - IDLE→FILL on the first accept.
  - FILL→FLUSH on the accept of the last pixel (eof). The flush counter loads FLUSH_CYCLES-1.
  - FLUSH decrements each cycle and moves to DONE when the counter equals 0. en is high for exactly FLUSH_CYCLES cycles after the eof write cycle.
  - DONE lasts 1 cycle with frame_done=1, then returns to IDLE with col, row and wr_sel at 0.
- Simultaneous events: in_valid during FLUSH or DONE is not accepted; upstream holds the pixel.
- Width rules:
  - Counters are unsigned and compared against IMG_W-1 and IMG_H-1 only, never against counter overflow.
  - The flush counter is 16 bits wide.

Optional Feature:
- Macro: LBW_STALL_CNT_EN.
- When defined:
  - Adds output `stall_cnt` [15:0], which counts FILL cycles with in_valid=0.
  - The count saturates at 16'hFFFF.
  - It clears on rst and on IDLE→FILL, and holds its value through FLUSH, DONE and IDLE until the next frame.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package contents:
  - State encoding typedef: IDLE=0, FILL=1, FLUSH=2, DONE=3.
  - Line-buffer count constant NUM_LB=3.
  - Flush counter width constant 16.
- Sub-module: pix_pos_counter, containing col/row/wr_sel counting and the sof/eol/eof decode. Instantiated once; everything else stays in the top.

Test Plan (IMG_W=4, IMG_H=3, FLUSH_CYCLES=5 unless stated):
- Contiguous frame, in_valid held at 1 for 12 pixels with data 1..12 → wr_en for 12 cycles.
  - wr_addr sequence 0,1,2,3 repeating; wr_sel 0,0,0,0,1,1,1,1,2,2,2,2.
  - sof on data 1, eol on data 4, 8 and 12, eof on data 12.
  - en high for 12+5 cycles, frame_done 1 cycle later.
- Gapped input, in_valid toggling 1,0 → wr_en toggles, en follows wr_en, counters advance only on accepts, final wr_addr=3 with eof.
- in_valid=1 during FLUSH → in_ready=0 and no wr_en until DONE→IDLE. The next frame starts at wr_addr=0, wr_sel=0 with sof.
- Reset mid-frame: rst after pixel 6 → next cycle all outputs 0 and no frame_done. The next pixel is written at wr_addr=0, wr_sel=0 with sof.
- Flush boundary with FLUSH_CYCLES=1 → en high exactly 1 cycle after the eof write, then frame_done.
- With LBW_STALL_CNT_EN, 3 idle cycles inserted mid-frame → stall_cnt=3 at frame_done; it clears on the next frame's first accept.

Source files
------------

// File: rtl/line_buffer_writer_pkg.sv
// ---------------------------------------------------------------------------
// line_buffer_writer_pkg
// Shared definitions for the line-buffer write controller:
//   - state_t / ST_* : writer FSM state encoding (IDLE=0, FILL=1, FLUSH=2, DONE=3)
//   - NUM_LB         : number of rotating line buffers
//   - FLUSH_W        : width of the post-frame flush counter
//   - next_lb()      : buffer-select rotation 0 -> 1 -> 2 -> 0
// ---------------------------------------------------------------------------
package line_buffer_writer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int NUM_LB  = 3;
    localparam int FLUSH_W = 16;

    // Advance to the next line buffer, wrapping after the last one.
    function automatic logic [1:0] next_lb(input logic [1:0] sel);
        if (sel == 2'(NUM_LB - 1)) begin
            return 2'd0;
        end else begin
            return sel + 2'd1;
        end
    endfunction

endpackage

// File: rtl/line_buffer_writer_pix_pos_counter.sv
// ---------------------------------------------------------------------------
// pix_pos_counter
// Column / row / line-buffer-select position tracker for the writer.
// The decode outputs describe the position of the pixel that would be
// accepted this cycle (i.e. the current counter values).
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   adv        : a pixel is accepted this cycle; advance the position
//   col        : current column (also the line-buffer write address)
//   sel        : current target line buffer (0..NUM_LB-1)
//   is_sof     : current position is (col 0, row 0)
//   is_eol     : current position is the last column
//   is_eof     : current position is the last pixel of the frame
// ---------------------------------------------------------------------------
module pix_pos_counter
    import line_buffer_writer_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [COL_W-1:0] col,
    output logic [1:0]       sel,
    output logic             is_sof,
    output logic             is_eol,
    output logic             is_eof
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [1:0]       sel_r;

    // Boundary decode of the current position.
    always_comb begin
        is_sof = (col_r == '0) && (row_r == '0);
        is_eol = (col_r == COL_LAST);
        is_eof = (col_r == COL_LAST) && (row_r == ROW_LAST);
    end

    // Position counters; the frame end also re-homes the buffer select so
    // every frame starts in buffer 0 whatever IMG_H is modulo NUM_LB.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
            sel_r <= 2'd0;
        end else if (adv) begin
            if (is_eol) begin
                col_r <= '0;
                if (is_eof) begin
                    row_r <= '0;
                    sel_r <= 2'd0;
                end else begin
                    row_r <= row_r + ROW_W'(1);
                    sel_r <= next_lb(sel_r);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    assign col = col_r;
    assign sel = sel_r;

endmodule

// File: rtl/line_buffer_writer.sv
// ---------------------------------------------------------------------------
// line_buffer_writer
// Write side of the filter-window line buffers. Accepts the raw pixel
// stream, writes each pixel into one of NUM_LB rotating line buffers one
// cycle after acceptance, drives `en` toward the read controller and, after
// the last pixel of a frame, holds `en` high for FLUSH_CYCLES cycles so the
// filter pipeline drains, then pulses frame_done.
// Optional feature (macro LBW_STALL_CNT_EN): adds stall_cnt, a saturating
// count of FILL cycles with no valid input, cleared at the start of a frame.
// Ports:
//   clk, rst         : rising-edge clock, synchronous active-high reset
//   in_valid/in_data : input pixel stream
//   in_ready         : writer can accept (IDLE or FILL, not in reset)
//   wr_en/addr/data  : line-buffer write port (addr = column)
//   wr_sel           : target line buffer 0..2
//   en               : enable toward the read controller
//   sof/eol/eof      : boundary flags qualifying wr_en
//   frame_done       : one-cycle pulse when the flush period ends
//   stall_cnt        : (LBW_STALL_CNT_EN only) input stall counter
// ---------------------------------------------------------------------------
module line_buffer_writer
    import line_buffer_writer_pkg::*;
#(
    parameter int IMG_W        = 640,
    parameter int IMG_H        = 480,
    parameter int DATA_W       = 8,
    parameter int COL_W        = 10,
    parameter int ROW_W        = 9,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [COL_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        wr_sel,
    output logic              en,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              frame_done
`ifdef LBW_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

    state_t             state_r;
    state_t             next_state_s;
    logic [FLUSH_W-1:0] flush_cnt_r;
    logic               accept_s;
    logic               ready_s;

    logic [COL_W-1:0]   col_s;
    logic [1:0]         sel_s;
    logic               is_sof_s;
    logic               is_eol_s;
    logic               is_eof_s;

    pix_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .adv    (accept_s),
        .col    (col_s),
        .sel    (sel_s),
        .is_sof (is_sof_s),
        .is_eol (is_eol_s),
        .is_eof (is_eof_s)
    );

    // Ready is the only combinational output: it must drop while rst is held.
    always_comb begin
        ready_s  = 1'b0;
        accept_s = 1'b0;
        if (rst) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (state_r == ST_IDLE) || (state_r == ST_FILL);
        end
        accept_s = in_valid && ready_s;
    end

    assign in_ready = ready_s;

    // Next-state logic of the writer FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_eof_s) begin
                    next_state_s = ST_FLUSH;
                end else if (accept_s) begin
                    next_state_s = ST_FILL;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s && is_eof_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == '0) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and flush countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= '0;
        end else begin
            state_r <= next_state_s;
            if (accept_s && is_eof_s) begin
                flush_cnt_r <= FLUSH_LOAD;
            end else if ((state_r == ST_FLUSH) && (flush_cnt_r != '0)) begin
                flush_cnt_r <= flush_cnt_r - FLUSH_W'(1);
            end
        end
    end

    // Registered write port and flags, one cycle after the accept. `en`
    // lags the FSM by the same cycle, so it covers the write cycles plus
    // exactly FLUSH_CYCLES cycles after the eof write, and frame_done lands
    // on the first cycle after `en` falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_sel     <= 2'd0;
            en         <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= accept_s;
            en         <= accept_s || (state_r == ST_FLUSH);
            sof        <= accept_s && is_sof_s;
            eol        <= accept_s && is_eol_s;
            eof        <= accept_s && is_eof_s;
            frame_done <= (state_r == ST_DONE);
            if (accept_s) begin
                wr_addr <= col_s;
                wr_data <= in_data;
                wr_sel  <= sel_s;
            end
        end
    end

`ifdef LBW_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of FILL cycles starved of input; restarts per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r == ST_IDLE) && accept_s) begin
            stall_cnt_r <= 16'd0;
        end else if ((state_r == ST_FILL) && !in_valid && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_line_buffer_writer.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_writer
// Self-checking bench for line_buffer_writer with IMG_W=4, IMG_H=3.
// dut drives FLUSH_CYCLES=5; dut1 (same stimulus) uses FLUSH_CYCLES=1 and is
// only examined during the first contiguous frame.
// Optional macro LBW_STALL_CNT_EN enables the stall_cnt checks.
// ---------------------------------------------------------------------------
module tb_line_buffer_writer;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [9:0] addr;
        logic [1:0] sel;
        logic       sof;
        logic       eol;
        logic       eof;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready, wr_en, en, sof, eol, eof, frame_done;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] wr_sel;

    logic       in_ready1, wr_en1, en1, sof1, eol1, eof1, frame_done1;
    logic [9:0] wr_addr1;
    logic [7:0] wr_data1;
    logic [1:0] wr_sel1;

`ifdef LBW_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt1;
`endif

    line_buffer_writer #(
        .IMG_W(4), .IMG_H(3), .DATA_W(8), .COL_W(10), .ROW_W(9), .FLUSH_CYCLES(5)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_sel(wr_sel), .en(en), .sof(sof), .eol(eol), .eof(eof),
        .frame_done(frame_done)
`ifdef LBW_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    line_buffer_writer #(
        .IMG_W(4), .IMG_H(3), .DATA_W(8), .COL_W(10), .ROW_W(9), .FLUSH_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .wr_sel(wr_sel1), .en(en1), .sof(sof1), .eol(eol1), .eof(eof1),
        .frame_done(frame_done1)
`ifdef LBW_STALL_CNT_EN
        , .stall_cnt(stall_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   en_cnt = 0, en1_cnt = 0, fd_cnt = 0, fd1_cnt = 0;
    int   last_en_cyc = 0, last_en1_cyc = 0, fd_cyc = 0, fd1_cyc = 0;
    vec_t sb[$];
    vec_t tc[12];
    vec_t tg[24];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sample registered outputs and retire scoreboard entries on writes.
    task automatic observe();
        vec_t e;
        if (en === 1'b1) begin en_cnt++; last_en_cyc = cyc; end
        if (en1 === 1'b1) begin en1_cnt++; last_en1_cyc = cyc; end
        if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
        if (frame_done1 === 1'b1) begin fd1_cnt++; fd1_cyc = cyc; end
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_wr: actual addr=%0d data=%0h, required no write",
                         wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                chk("wr", {41'd0, wr_addr, wr_data, wr_sel, sof, eol, eof},
                          {41'd0, e.addr, e.data, e.sel, e.sof, e.eol, e.eof});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic apply(input vec_t v);
        in_valid = v.valid;
        in_data  = v.data;
        if (v.valid) sb.push_back(v);
        step();
    endtask

    task automatic apply_tc(input int first, input int last);
        for (int i = first; i <= last; i++) apply(tc[i]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Drain until frame_done, then check en length and the en->frame_done gap.
    task automatic wait_frame(input string name, input int en_base, input int exp_en);
        int fd0;
        int n;
        fd0 = fd_cnt;
        n = 0;
        in_valid = 1'b0;
        while (fd_cnt == fd0 && n < 60) begin
            step();
            n++;
        end
        if (fd_cnt == fd0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: actual no frame_done in %0d cycles, required a pulse", name, n);
        end else begin
            chk({name, "_en_cycles"}, 64'(en_cnt - en_base), 64'(exp_en));
            chk({name, "_fd_gap"}, 64'(fd_cyc - last_en_cyc), 64'd1);
        end
    endtask

    initial begin
        int en_base, en1_base, fd_base, fd1_base;
        vec_t p;

        for (int i = 0; i < 12; i++) begin
            tc[i].valid = 1'b1;
            tc[i].data  = 8'(i + 1);
            tc[i].addr  = 10'(i % 4);
            tc[i].sel   = 2'(i / 4);
            tc[i].sof   = (i == 0);
            tc[i].eol   = ((i % 4) == 3);
            tc[i].eof   = (i == 11);
        end
        for (int j = 0; j < 24; j++) begin
            tg[j] = tc[j / 2];
            tg[j].data = 8'h40 + 8'(j / 2);
            tg[j].valid = ((j % 2) == 0);
        end

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        step();
        step();
        chk("reset_outputs",
            {39'd0, wr_en, en, sof, eol, eof, frame_done, wr_addr, wr_data, wr_sel, in_ready},
            64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        // Contiguous frame; dut1 checks the single-cycle flush.
        en_base = en_cnt; en1_base = en1_cnt; fd1_base = fd1_cnt;
        apply_tc(0, 11);
        wait_frame("contig", en_base, 17);
        chk("flush1_en_cycles", 64'(en1_cnt - en1_base), 64'd13);
        chk("flush1_fd_count", 64'(fd1_cnt - fd1_base), 64'd1);
        chk("flush1_fd_gap", 64'(fd1_cyc - last_en1_cyc), 64'd1);

        // Gapped frame: valid toggles 1,0.
        en_base = en_cnt;
        for (int j = 0; j < 24; j++) apply(tg[j]);
        wait_frame("gapped", en_base, 17);
`ifdef LBW_STALL_CNT_EN
        chk("gapped_stall_cnt", 64'(stall_cnt), 64'd11);
`endif

        // in_valid held through FLUSH and DONE.
        en_base = en_cnt; fd_base = fd_cnt;
        apply_tc(0, 11);
        in_valid = 1'b1;
        in_data = 8'hA5;
        for (int k = 0; k < 6; k++) begin
            chk("ready_low_flush_done", 64'(in_ready), 64'd0);
            step();
        end
        chk("hold_en_cycles", 64'(en_cnt - en_base), 64'd17);
        chk("hold_fd_count", 64'(fd_cnt - fd_base), 64'd1);
        chk("hold_fd_gap", 64'(fd_cyc - last_en_cyc), 64'd1);
        chk("ready_back_idle", 64'(in_ready), 64'd1);
        p = tc[0];
        p.data = 8'hA5;
        apply(p);

        // Reset after pixel 6 of the new frame.
        apply_tc(1, 5);
        fd_base = fd_cnt;
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        chk("midreset_outputs",
            {39'd0, wr_en, en, sof, eol, eof, frame_done, wr_addr, wr_data, wr_sel, in_ready},
            64'd0);
        rst = 1'b0;
        #1;
        chk("midreset_ready", 64'(in_ready), 64'd1);
        idle(8);
        chk("midreset_no_fd", 64'(fd_cnt - fd_base), 64'd0);
        en_base = en_cnt;
        apply_tc(0, 11);
        wait_frame("after_reset", en_base, 17);

        // Three stall cycles mid-frame, then the next frame's first accept.
        en_base = en_cnt;
        apply_tc(0, 5);
        idle(3);
        apply_tc(6, 11);
        wait_frame("stalled", en_base, 17);
`ifdef LBW_STALL_CNT_EN
        chk("stall_cnt_at_done", 64'(stall_cnt), 64'd3);
`endif
        apply_tc(0, 0);
`ifdef LBW_STALL_CNT_EN
        chk("stall_cnt_cleared", 64'(stall_cnt), 64'd0);
`endif
        en_base = en_cnt - 1;
        apply_tc(1, 11);
        wait_frame("last", en_base, 17);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1);
    end

endmodule
